oam_dma_ctrl: RTL and testbench

OAM DMA controller behind MMIO register 0xFF46. A CPU write of page P copies 160 bytes from P<<8 to OAM at 0xFE00-0xFE9F. During the copy it takes the main bus from the CPU via cpu_mem_disable; the top level muxes dma_rd, dma_wr, dma_a and dma_dout onto the bus. It runs on the 4.19 MHz clk, and each byte takes one machine cycle (4 clocks).

---
 rtl/oam_dma_ctrl.sv | 168 ++++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// ----------------------------------------------------------------------------
// oam_dma_ctrl
//   OAM DMA engine behind the 0xFF46 register. A CPU write of page P copies
//   XFER_LEN bytes from {P,8'h00} to OAM at 0xFE00. It waits START_DELAY
//   clocks, then takes the bus (cpu_mem_disable=1). Each byte takes one
//   machine cycle of 4 clocks: two read clocks, one write clock, one idle
//   clock.
//
//   Optional build macro: OAM_DMA_ECHO_FOLD_EN
//     defined   - source pages 0xE0-0xFF are folded down by 0x20 (echo RAM)
//     undefined - the source page is used verbatim
//
// Ports
//   clk             in   system clock (4.19 MHz)
//   rst             in   synchronous reset, active-high
//   mmio_wr         in   one-clock write strobe for 0xFF46
//   mmio_din[7:0]   in   source page written by the CPU
//   mmio_dout[7:0]  out  last written page (unfolded)
//   dma_rd          out  bus read enable
//   dma_wr          out  bus write enable
//   dma_a[15:0]     out  bus address
//   dma_din[7:0]    in   bus read data, one clock after dma_rd/dma_a
//   dma_dout[7:0]   out  bus write data
//   cpu_mem_disable out  high while the DMA owns the bus
//
//   The bus interface has no handshake: the DMA never waits. A read is
//   presented in phase 0 and held in phase 1. The synchronous RAM returns
//   the data during phase 1, and the data is latched at the end of that
//   phase.
// ----------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter int XFER_LEN    = 160,
    parameter int START_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr,
    input  logic [7:0]  mmio_din,
    output logic [7:0]  mmio_dout,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic [15:0] dma_a,
    input  logic [7:0]  dma_din,
    output logic [7:0]  dma_dout,
    output logic        cpu_mem_disable
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    localparam logic [8:0] LP_LEN   = 9'(XFER_LEN);
    localparam logic [7:0] LP_DLY_M1 = 8'(START_DELAY - 1);

    state_t      r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic [1:0]  r_phase;
    logic [7:0]  r_latch;
    logic [7:0]  r_dcnt;

    state_t      w_state_nxt;
    logic [7:0]  w_index_nxt;
    logic [1:0]  w_phase_nxt;
    logic [7:0]  w_latch_nxt;
    logic [7:0]  w_dcnt_nxt;
    logic [7:0]  w_src_page;
    logic [8:0]  w_index_inc;

`ifdef OAM_DMA_ECHO_FOLD_EN
    // 0xE0-0xFF mirrors WRAM at 0xC0-0xDF.
    assign w_src_page = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;
`else
    assign w_src_page = r_page;
`endif

    // 9 bits wide so that XFER_LEN = 256 still terminates.
    assign w_index_inc = {1'b0, r_index} + 9'd1;

    assign mmio_dout = r_page;

    always_comb begin
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_phase_nxt     = r_phase;
        w_latch_nxt     = r_latch;
        w_dcnt_nxt      = r_dcnt;
        dma_rd          = 1'b0;
        dma_wr          = 1'b0;
        dma_a           = 16'h0000;
        dma_dout        = 8'h00;
        cpu_mem_disable = 1'b0;

        case (r_state)
            S_DELAY: begin
                if (r_dcnt == 8'd0) begin
                    w_state_nxt = S_XFER;
                    w_index_nxt = 8'd0;
                    w_phase_nxt = 2'd0;
                end else begin
                    w_dcnt_nxt = r_dcnt - 8'd1;
                end
            end
            S_XFER: begin
                cpu_mem_disable = 1'b1;
                w_phase_nxt     = r_phase + 2'd1;
                case (r_phase)
                    2'd0: begin
                        dma_a  = {w_src_page, r_index};
                        dma_rd = 1'b1;
                    end
                    2'd1: begin
                        dma_a       = {w_src_page, r_index};
                        dma_rd      = 1'b1;
                        w_latch_nxt = dma_din;
                    end
                    2'd2: begin
                        dma_a    = {8'hFE, r_index};
                        dma_wr   = 1'b1;
                        dma_dout = r_latch;
                    end
                    default: begin
                        dma_a       = {8'hFE, r_index};
                        w_index_nxt = w_index_inc[7:0];
                        if (w_index_inc == LP_LEN) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                endcase
            end
            default: begin
                // S_IDLE: bus released, nothing pending.
            end
        endcase

        // A register write from any state restarts the transfer. It also
        // overrides the final phase 3 return to IDLE.
        if (mmio_wr) begin
            w_state_nxt = S_DELAY;
            w_dcnt_nxt  = LP_DLY_M1;
            w_index_nxt = 8'd0;
            w_phase_nxt = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_index <= 8'd0;
            r_phase <= 2'd0;
            r_latch <= 8'h00;
            r_dcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_phase <= w_phase_nxt;
            r_latch <= w_latch_nxt;
            r_dcnt  <= w_dcnt_nxt;
            if (mmio_wr) begin
                r_page <= mmio_din;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  localparam int LEN = 160;
  localparam int SD  = 4;

  logic        clk;
  logic        rst;
  logic        mmio_wr;
  logic [7:0]  mmio_din;
  logic [7:0]  mmio_dout;
  logic        dma_rd;
  logic        dma_wr;
  logic [15:0] dma_a;
  logic [7:0]  dma_din;
  logic [7:0]  dma_dout;
  logic        cpu_mem_disable;

  oam_dma_ctrl #(.XFER_LEN(LEN), .START_DELAY(SD)) dut (
    .clk(clk), .rst(rst), .mmio_wr(mmio_wr), .mmio_din(mmio_din),
    .mmio_dout(mmio_dout), .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_a(dma_a),
    .dma_din(dma_din), .dma_dout(dma_dout), .cpu_mem_disable(cpu_mem_disable)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus memory (synchronous read) ----------------
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] rd_q;
  assign dma_din = rd_q;

  always @(posedge clk) begin
    if (dma_rd) rd_q <= mem[dma_a];
    if (dma_wr) mem[dma_a] = dma_dout;
  end

  // ---------------- scoreboard / counters ----------------
  int n_vec = 0;
  int n_err = 0;
  int dis_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_tick counts clocks since the accepted register write (-1 = idle).
  int         m_tick = -1;
  logic [7:0] m_page = 8'h00;

  function automatic logic [7:0] src_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_FOLD_EN
    return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
    return p;
`endif
  endfunction

  // One clock: check outputs on the falling edge, drive inputs for the next
  // rising edge, then advance the model across that edge.
  task automatic step(input logic wr, input logic [7:0] din, input logic r);
    int t, b, ph;
    logic        e_dis, e_rd, e_wr;
    logic [15:0] e_a, src;
    logic [7:0]  e_dout;
    @(negedge clk);
    e_dis = 0; e_rd = 0; e_wr = 0; e_a = 16'h0000; e_dout = 8'h00;
    t = m_tick - SD;
    if (m_tick >= 0 && t >= 0 && t < LEN * 4) begin
      b   = t / 4;
      ph  = t % 4;
      src = {src_page(m_page), 8'h00} + 16'(b);
      e_dis = 1;
      e_rd  = (ph < 2);
      e_wr  = (ph == 2);
      e_a   = (ph < 2) ? src : 16'hFE00 + 16'(b);
      if (ph == 2) begin
        e_dout = ref_mem[src];
        ref_mem[16'hFE00 + 16'(b)] = ref_mem[src];
      end
    end
    if (cpu_mem_disable) dis_cnt++;
    chk("cpu_mem_disable", {31'd0, cpu_mem_disable}, {31'd0, e_dis});
    chk("dma_rd", {31'd0, dma_rd}, {31'd0, e_rd});
    chk("dma_wr", {31'd0, dma_wr}, {31'd0, e_wr});
    chk("rd_and_wr", {31'd0, dma_rd & dma_wr}, 32'd0);
    chk("dma_a", {16'd0, dma_a}, {16'd0, e_a});
    if (e_wr) chk("dma_dout", {24'd0, dma_dout}, {24'd0, e_dout});
    chk("mmio_dout", {24'd0, mmio_dout}, {24'd0, m_page});
    mmio_wr  = wr;
    mmio_din = din;
    rst      = r;
    if (r) begin
      m_tick = -1;
      m_page = 8'h00;
    end else if (wr) begin
      m_tick = 0;
      m_page = din;
    end else if (m_tick >= 0) begin
      m_tick++;
      if (m_tick == SD + LEN * 4) m_tick = -1;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr_page(input logic [7:0] p);
    step(1'b1, p, 1'b0);
  endtask

  task automatic check_oam_ref(input string tag);
    for (int i = 0; i < LEN; i++)
      chk(tag, {24'd0, mem[16'hFE00 + 16'(i)]}, {24'd0, ref_mem[16'hFE00 + 16'(i)]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  p;
    logic [15:0] es;
    rst = 1'b1; mmio_wr = 1'b0; mmio_din = 8'h00;
    rd_q = 8'h00;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'($urandom);
      ref_mem[a] = mem[a];
    end
    repeat (2) @(posedge clk);
    // reset state
    step(1'b0, 8'h00, 1'b1);
    run(3);

    // basic copy from 0xC1 with a known pattern
    for (int i = 0; i < LEN; i++) begin
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      ref_mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
    end
    dis_cnt = 0;
    wr_page(8'hC1);
    run(SD + LEN * 4 + 6);
    chk("own_clocks", 32'(dis_cnt), 32'(LEN * 4));
    for (int i = 0; i < LEN; i++)
      chk("oam_pattern", {24'd0, mem[16'hFE00 + 16'(i)]}, {24'd0, 8'(i) ^ 8'h5A});

    // restart at transfer clock 200 (byte 50)
    wr_page(8'hC0);
    run(SD + 200 - 1);
    wr_page(8'hC2);
    run(SD + LEN * 4 + 6);
    for (int i = 0; i < LEN; i++)
      chk("oam_restart", {24'd0, mem[16'hFE00 + 16'(i)]}, {24'd0, ref_mem[16'hC200 + 16'(i)]});

    // reset mid-transfer, then a clean transfer
    wr_page(8'hC0);
    run(SD + 300 - 1);
    step(1'b0, 8'h00, 1'b1);
    run(5);
    wr_page(8'hC0);
    run(SD + LEN * 4 + 6);
    check_oam_ref("oam_after_reset");

    // echo page
    wr_page(8'hE3);
    run(SD + LEN * 4 + 6);
    es = {src_page(8'hE3), 8'h00};
    for (int i = 0; i < LEN; i++)
      chk("oam_echo", {24'd0, mem[16'hFE00 + 16'(i)]}, {24'd0, ref_mem[es + 16'(i)]});

    // restart coincident with the final phase 3
    wr_page(8'hC1);
    for (int k = 0; k < 800 && m_tick != SD + LEN * 4 - 1; k++) run(1);
    chk("reach_last_phase", 32'(m_tick), 32'(SD + LEN * 4 - 1));
    wr_page(8'hC4);
    dis_cnt = 0;
    run(SD + LEN * 4 + 6);
    chk("own_clocks_b2b", 32'(dis_cnt), 32'(LEN * 4));
    check_oam_ref("oam_b2b");

    // random pages with random restarts
    for (int it = 0; it < 6; it++) begin
      p = 8'($urandom_range(8'hC0, 8'hDF));
      wr_page(p);
      run($urandom_range(0, 700));
      if ($urandom_range(0, 1) == 1) begin
        wr_page(8'($urandom_range(8'hC0, 8'hDF)));
      end
      run(SD + LEN * 4 + 6);
      check_oam_ref("oam_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
